// File: rtl/reg_file_mp.sv
// Multi-port register file: two registered read ports, two write ports, and a sequential clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  write_en_a,
  input  logic [ADDR_WIDTH-1:0] write_addr_a,
  input  logic [DATA_WIDTH-1:0] write_data_a,
  input  logic                  write_en_b,
  input  logic [ADDR_WIDTH-1:0] write_addr_b,
  input  logic [DATA_WIDTH-1:0] write_data_b,
  input  logic                  clear_req,
  output logic                  clear_busy
);

  localparam int REG_NUM = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clear_cnt, clear_cnt_next;
  logic [DATA_WIDTH-1:0]   regs [REG_NUM];
  logic                    wr_a, wr_b;
  logic [DATA_WIDTH-1:0]   rd_next_1, rd_next_2;

  assign clear_busy = (state == CLEAR);
  assign wr_a = write_en_a && (write_addr_a != '0) && !clear_busy;
  assign wr_b = write_en_b && (write_addr_b != '0) && !clear_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clear_cnt <= '0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
    end
  end

  // The counter parks on the last address when the sweep finishes.
  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next     = CLEAR;
          clear_cnt_next = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      CLEAR: begin
        if (clear_cnt == LAST_ADDR) state_next = IDLE;
        else clear_cnt_next = clear_cnt + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Port B is assigned last so it wins on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (clear_busy) begin
      regs[clear_cnt] <= '0;
    end else begin
      if (wr_a) regs[write_addr_a] <= write_data_a;
      if (wr_b) regs[write_addr_b] <= write_data_b;
    end
  end

  always_comb begin
    rd_next_1 = regs[read_addr_1];
`ifdef REGFILE_BYPASS_EN
    if (wr_b && (write_addr_b == read_addr_1))      rd_next_1 = write_data_b;
    else if (wr_a && (write_addr_a == read_addr_1)) rd_next_1 = write_data_a;
`endif
    if (!read_en_1 || (read_addr_1 == '0) || clear_busy) rd_next_1 = '0;
  end

  always_comb begin
    rd_next_2 = regs[read_addr_2];
`ifdef REGFILE_BYPASS_EN
    if (wr_b && (write_addr_b == read_addr_2))      rd_next_2 = write_data_b;
    else if (wr_a && (write_addr_a == read_addr_2)) rd_next_2 = write_data_a;
`endif
    if (!read_en_2 || (read_addr_2 == '0) || clear_busy) rd_next_2 = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_1 <= '0;
      read_data_2 <= '0;
    end else begin
      read_data_1 <= rd_next_1;
      read_data_2 <= rd_next_2;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RN = 1 << AW;

  logic          clk, rst;
  logic          read_en_1, read_en_2;
  logic [AW-1:0] read_addr_1, read_addr_2;
  logic [DW-1:0] read_data_1, read_data_2;
  logic          write_en_a, write_en_b;
  logic [AW-1:0] write_addr_a, write_addr_b;
  logic [DW-1:0] write_data_a, write_data_b;
  logic          clear_req, clear_busy;

  typedef struct {
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          busy;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem [RN];
  int            clear_left;
  int            n_cmp, n_bad;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .read_en_1(read_en_1), .read_addr_1(read_addr_1), .read_data_1(read_data_1),
    .read_en_2(read_en_2), .read_addr_2(read_addr_2), .read_data_2(read_data_2),
    .write_en_a(write_en_a), .write_addr_a(write_addr_a), .write_data_a(write_data_a),
    .write_en_b(write_en_b), .write_addr_b(write_addr_b), .write_data_b(write_data_b),
    .clear_req(clear_req), .clear_busy(clear_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference read: a clear in progress hides everything, address 0 is hard zero.
  function automatic logic [DW-1:0] model_read(input bit en, input int addr, input bit busy_now,
                                               input bit wea, input int waa, input logic [DW-1:0] wda,
                                               input bit web, input int wab, input logic [DW-1:0] wdb);
    if (!en || addr == 0 || busy_now) return '0;
`ifdef REGFILE_BYPASS_EN
    if (web && wab == addr) return wdb;
    if (wea && waa == addr) return wda;
`endif
    return mem[addr];
  endfunction

  // A clear is modelled as zeroing everything at once and counting down the busy cycles.
  task automatic apply_stimulus(input bit re1, input int ra1, input bit re2, input int ra2,
                                input bit wea, input int waa, input logic [DW-1:0] wda,
                                input bit web, input int wab, input logic [DW-1:0] wdb,
                                input bit clr);
    exp_t e;
    bit   busy_now;
    @(negedge clk);
    read_en_1 = re1;  read_addr_1 = AW'(ra1);
    read_en_2 = re2;  read_addr_2 = AW'(ra2);
    write_en_a = wea; write_addr_a = AW'(waa); write_data_a = wda;
    write_en_b = web; write_addr_b = AW'(wab); write_data_b = wdb;
    clear_req = clr;
    busy_now = (clear_left > 0);
    e.rd1 = model_read(re1, ra1, busy_now, wea, waa, wda, web, wab, wdb);
    e.rd2 = model_read(re2, ra2, busy_now, wea, waa, wda, web, wab, wdb);
    if (!busy_now) begin
      if (wea && waa != 0) mem[waa] = wda;
      if (web && wab != 0) mem[wab] = wdb;
      if (clr) begin
        for (int i = 0; i < RN; i++) mem[i] = '0;
        clear_left = RN - 1;
      end
    end else begin
      clear_left--;
    end
    e.busy = (clear_left > 0);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic read_pair(input int a1, input int a2);
    apply_stimulus(1, a1, 1, a2, 0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic random_cycle(input int clr_odds);
    int  waa, wab, ra1, ra2;
    bit  clr;
    waa = $urandom_range(0, RN - 1);
    wab = ($urandom_range(0, 3) == 0) ? waa : $urandom_range(0, RN - 1);
    ra1 = ($urandom_range(0, 3) == 0) ? waa : $urandom_range(0, RN - 1);
    ra2 = ($urandom_range(0, 3) == 0) ? wab : $urandom_range(0, RN - 1);
    clr = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
    apply_stimulus($urandom_range(0, 1), ra1, $urandom_range(0, 1), ra2,
                   $urandom_range(0, 1), waa, $urandom(), $urandom_range(0, 1), wab, $urandom(), clr);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop before any clock.
  task automatic do_reset();
    @(negedge clk);
    read_en_1 = 0; read_en_2 = 0; write_en_a = 0; write_en_b = 0; clear_req = 0;
    #2 rst = 1'b1;
    #1;
    check_output("async_rst_read_data_1", read_data_1, '0);
    check_output("async_rst_read_data_2", read_data_2, '0);
    check_output("async_rst_clear_busy", DW'(clear_busy), '0);
    for (int i = 0; i < RN; i++) mem[i] = '0;
    clear_left = 0;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("read_data_1", read_data_1, e.rd1);
        check_output("read_data_2", read_data_2, e.rd2);
        check_output("clear_busy", DW'(clear_busy), DW'(e.busy));
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; clear_left = 0;
    for (int i = 0; i < RN; i++) mem[i] = '0;
    rst = 1'b1;
    read_en_1 = 0; read_addr_1 = '0; read_en_2 = 0; read_addr_2 = '0;
    write_en_a = 0; write_addr_a = '0; write_data_a = '0;
    write_en_b = 0; write_addr_b = '0; write_data_b = '0;
    clear_req = 0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_read_data_1", read_data_1, '0);
    check_output("reset_read_data_2", read_data_2, '0);
    check_output("reset_clear_busy", DW'(clear_busy), '0);
    #2 rst = 1'b0;

    // Basic write then read, port-B priority on collision, bypass/pre-write read, address 0.
    apply_stimulus(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, '0, 0);
    read_pair(3, 3);
    apply_stimulus(0, 0, 0, 0, 1, 7, 32'h11111111, 1, 7, 32'h22222222, 0);
    read_pair(7, 3);
    apply_stimulus(0, 0, 1, 5, 1, 5, 32'hA5A5A5A5, 0, 0, '0, 0);
    read_pair(5, 5);
    apply_stimulus(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0);
    read_pair(0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 10, 32'h0000AAAA, 1, 11, 32'h0000BBBB, 0);
    read_pair(10, 11);

    // Fill every register, then clear with a coincident write; writes and clear_req during the sweep are lost.
    for (int i = 1; i < RN; i += 2)
      apply_stimulus(0, 0, 0, 0, 1, i, 32'hC0DE0000 + i, 1, (i + 1) % RN, 32'hBEEF0000 + i, 0);
    read_pair(1, RN - 1);
    apply_stimulus(1, 4, 1, 6, 1, 4, 32'h44444444, 0, 0, '0, 1);
    for (int i = 0; i < RN - 1; i++)
      apply_stimulus(1, i + 1, 1, 2, 1, i + 1, $urandom(), 1, 2, $urandom(), (i == 5));
    for (int i = 0; i < RN; i += 2) read_pair(i, i + 1);

    // Reset part-way through a clear, then normal use straight after release.
    for (int i = 1; i < RN; i++) apply_stimulus(0, 0, 0, 0, 1, i, 32'h5A000000 + i, 0, 0, '0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, '0, 0, 0, '0, 1);
    for (int i = 0; i < 9; i++) read_pair(9, 12);
    do_reset();
    apply_stimulus(0, 0, 0, 0, 1, 9, 32'h12345678, 0, 0, '0, 0);
    read_pair(9, 12);

    for (int i = 0; i < 600; i++) random_cycle(60);
    for (int i = 0; i < RN; i += 2) read_pair(i, i + 1);
    idle_cycle();

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register address width; depth REG_NUM = 2**ADDR_WIDTH.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports read_en_1/read_en_2  input  1 each  read enable per port.
REQ-006 The block SHALL have ports read_addr_1/read_addr_2  input  ADDR_WIDTH each  read address.
REQ-007 The block SHALL have ports read_data_1/read_data_2  output  DATA_WIDTH each  registered read data.
REQ-008 The block SHALL have ports write_en_a/write_en_b  input  1 each  write enable per write port.
REQ-009 The block SHALL have ports write_addr_a/write_addr_b  input  ADDR_WIDTH each  write address.
REQ-010 The block SHALL have ports write_data_a/write_data_b  input  DATA_WIDTH each  write data.
REQ-011 The block SHALL have port clear_req  input  1  single-cycle request to zero whole file.
REQ-012 The block SHALL have port clear_busy  output  1  high while clear sequence runs.

Function
REQ-013 Register 0 SHALL always read zero; writes to address 0 SHALL be discarded.
REQ-014 Reads SHALL have 1-cycle latency: read_data_N updates on the edge after read_en_N/read_addr_N are sampled.
REQ-015 read_data_N SHALL load zero when read_en_N is low, when read_addr_N is 0, or when clear_busy is high.
REQ-016 Writes SHALL commit on the rising edge when write_en_x is high, address nonzero, and clear_busy low.
REQ-017 Simultaneous writes from A and B to the same address SHALL commit write_data_b (port B wins).
REQ-018 Writes to different addresses in the same cycle SHALL both commit.
REQ-019 Clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR when clear_req high in IDLE.
REQ-020 In CLEAR, a counter starting at 1 SHALL zero one register per cycle, incrementing each cycle.
REQ-021 CLEAR->IDLE SHALL occur on the cycle the counter zeroes REG_NUM-1; counter does not wrap further.
REQ-022 clear_busy SHALL be high exactly while state is CLEAR (REG_NUM-1 cycles, 31 at default).
REQ-023 clear_req while in CLEAR SHALL be ignored; write enables while in CLEAR SHALL be ignored and lost.
REQ-024 clear_req coincident with a write in IDLE: the write SHALL commit on that edge, then clear overwrites it.

Reset
REQ-025 Asserting rst SHALL immediately, without a clock, zero all registers, read_data_1, read_data_2, counter, and force state IDLE with clear_busy 0.
REQ-026 rst asserted mid-CLEAR SHALL abort the sequence; after release the block SHALL be IDLE with all registers zero.
REQ-027 First edge after rst deasserts SHALL perform normal operation (no extra idle cycle).

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined, a read whose nonzero address matches an enabled write in the same cycle SHALL return that write data (port B data if both match).
REQ-030 Without REGFILE_BYPASS_EN, such a read SHALL return the register's pre-write contents.
REQ-031 Bypass SHALL never apply while clear_busy is high or for address 0.

Verification
REQ-032 Write A addr 3 = 0xDEADBEEF, next cycle read port 1 addr 3 -> read_data_1 = 0xDEADBEEF one cycle later.
REQ-033 Same cycle A and B write addr 7 (0x11111111, 0x22222222), then read addr 7 -> 0x22222222.
REQ-034 Write addr 5 = 0xA5A5A5A5 while port 2 reads addr 5 same cycle -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, prior value 0 without.
REQ-035 Write addr 0 = 0xFFFFFFFF, read addr 0 -> 0x00000000.
REQ-036 Fill regs 1..31 with nonzero, pulse clear_req -> clear_busy high 31 cycles, writes during it ignored, all reads then 0.
REQ-037 Assert rst asynchronously at cycle 10 of a clear -> clear_busy and read_data drop to 0 at once; after release a write/read of addr 9 = 0x12345678 works.
